// File: rtl/num_display_ctrl_pkg.sv
// Shared definitions for the multi-value two-digit display controller.
package num_display_ctrl_pkg;

  // Conversion sequencer states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_CAPTURE,
    S_COMMIT
  } state_e;

  // BCD code the 7-segment decoder renders as an unlit digit.
  localparam logic [3:0] BCD_BLANK   = 4'hF;

  // Largest value representable on two digits.
  localparam logic [7:0] MAX_DISPLAY = 8'd99;

  // Clamp a value to the two-digit range before it reaches the separator.
  function automatic logic [7:0] sat_display(input logic [7:0] v);
    return (v > MAX_DISPLAY) ? MAX_DISPLAY : v;
  endfunction

endpackage

// File: rtl/num_display_ctrl_if.sv
// Bus between the controller and the shared two-digit separator.
interface num_display_ctrl_if;
  logic [7:0] numero;
  logic       update;
  logic [7:0] decenas;
  logic [7:0] unidades;

  modport master (output numero, output update, input decenas, input unidades);
  modport slave  (input numero, input update, output decenas, output unidades);
endinterface

// File: rtl/num_display_ctrl_scan_mux.sv
// Digit scanner: free-running slot divider, one-hot digit select and the
// tens-digit leading-zero blanking mux over the committed display digits.
module num_display_ctrl_scan_mux
  import num_display_ctrl_pkg::*;
#(
  parameter int NUM_VALUES = 2,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    blank_lz,
  input  logic [4*NUM_VALUES-1:0] disp_tens,
  input  logic [4*NUM_VALUES-1:0] disp_units,
  output logic [3:0]              digit_bcd,
  output logic [2*NUM_VALUES-1:0] digit_sel
);

  localparam int SLOTS = 2 * NUM_VALUES;
  localparam int IDX_W = $clog2(SLOTS);
  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] val_idx;
  logic [3:0]       tens_dig;
  logic [3:0]       units_dig;

  // Divider wrap advances the slot index, wrapping after the last units slot.
  always_comb begin
    div_d = div_q + 1'b1;
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IDX_W'(SLOTS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Divider and slot index registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      idx_q <= '0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
    end
  end

  // Even slots show tens, odd slots units; a zero tens digit may be blanked.
  always_comb begin
    val_idx   = idx_q >> 1;
    tens_dig  = disp_tens[4*val_idx +: 4];
    units_dig = disp_units[4*val_idx +: 4];
    digit_sel = '0;
    digit_sel[idx_q] = 1'b1;
    if (idx_q[0]) begin
      digit_bcd = units_dig;
    end else if (blank_lz && (tens_dig == 4'd0)) begin
      digit_bcd = BCD_BLANK;
    end else begin
      digit_bcd = tens_dig;
    end
  end

endmodule

// File: rtl/num_separator.sv
// Shared two-digit separator: splits numero into tens and units on the
// rising edge of update. Results hold until the next update edge.
module num_separator (
  num_display_ctrl_if.slave sep
);

  // Capture the split on each update rising edge.
  always_ff @(posedge sep.update) begin
    sep.decenas  <= sep.numero / 8'd10;
    sep.unidades <= sep.numero % 8'd10;
  end

endmodule

// File: rtl/num_display_ctrl.sv
// Sequences NUM_VALUES values through the shared separator, commits the
// digit set atomically and hands it to the scan multiplexer.
module num_display_ctrl
  import num_display_ctrl_pkg::*;
#(
  parameter int NUM_VALUES = 2,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [8*NUM_VALUES-1:0] values_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [7:0]              sep_numero,
  output logic                    sep_update,
  input  logic [7:0]              sep_decenas,
  input  logic [7:0]              sep_unidades,
  output logic [3:0]              digit_bcd,
  output logic [2*NUM_VALUES-1:0] digit_sel,
  output logic                    busy,
  output logic [NUM_VALUES-1:0]   overflow
);

  localparam int VIDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;

  state_e                  state_q, state_d;
  logic [VIDX_W-1:0]       idx_q, idx_d;
  logic [8*NUM_VALUES-1:0] snap_q, snap_d;
  logic                    pending_q, pending_d;
  logic [7:0]              numero_q, numero_d;
  logic                    update_q, update_d;
  logic [4*NUM_VALUES-1:0] stg_tens_q, stg_tens_d;
  logic [4*NUM_VALUES-1:0] stg_units_q, stg_units_d;
  logic [NUM_VALUES-1:0]   stg_ovf_q, stg_ovf_d;
  logic [4*NUM_VALUES-1:0] disp_tens_q, disp_tens_d;
  logic [4*NUM_VALUES-1:0] disp_units_q, disp_units_d;
  logic [NUM_VALUES-1:0]   ovf_q, ovf_d;
  logic [7:0]              cur_value;
  logic                    unused_sep_hi;

  // The separator only ever produces single digits; upper nibbles are ignored.
  assign unused_sep_hi = ^{sep_decenas[7:4], sep_unidades[7:4]};

  // Next-state and datapath for the conversion pass.
  // NOTE: every _d is defaulted to its _q first, so no path through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    pending_d    = pending_q;
    numero_d     = numero_q;
    update_d     = update_q;
    stg_tens_d   = stg_tens_q;
    stg_units_d  = stg_units_q;
    stg_ovf_d    = stg_ovf_q;
    disp_tens_d  = disp_tens_q;
    disp_units_d = disp_units_q;
    ovf_d        = ovf_q;
    cur_value    = snap_q[8*idx_q +: 8];

    case (state_q)
      S_IDLE: begin
        if (load || pending_q) begin
          snap_d    = values_in;
          pending_d = 1'b0;
          idx_d     = '0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        numero_d = sat_display(cur_value);
        update_d = 1'b0;
        state_d  = S_PULSE;
      end
      S_PULSE: begin
        update_d = 1'b1;
        state_d  = S_CAPTURE;
      end
      S_CAPTURE: begin
        update_d                  = 1'b0;
        stg_tens_d[4*idx_q +: 4]  = sep_decenas[3:0];
        stg_units_d[4*idx_q +: 4] = sep_unidades[3:0];
        stg_ovf_d[idx_q]          = (cur_value > MAX_DISPLAY);
        if (idx_q == VIDX_W'(NUM_VALUES - 1)) begin
          state_d = S_COMMIT;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SETUP;
        end
      end
      S_COMMIT: begin
        disp_tens_d  = stg_tens_q;
        disp_units_d = stg_units_q;
        ovf_d        = stg_ovf_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A request during a pass queues exactly one more pass.
    if ((state_q != S_IDLE) && load) begin
      pending_d = 1'b1;
    end
  end

  // Sequencer, staging and display registers.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      snap_q       <= '0;
      pending_q    <= 1'b0;
      numero_q     <= '0;
      update_q     <= 1'b0;
      // NOTE: digit storage is reset too, so a reset mid-pass can never leave stale digits on the display.
      stg_tens_q   <= '0;
      stg_units_q  <= '0;
      stg_ovf_q    <= '0;
      disp_tens_q  <= '0;
      disp_units_q <= '0;
      ovf_q        <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      pending_q    <= pending_d;
      numero_q     <= numero_d;
      update_q     <= update_d;
      stg_tens_q   <= stg_tens_d;
      stg_units_q  <= stg_units_d;
      stg_ovf_q    <= stg_ovf_d;
      disp_tens_q  <= disp_tens_d;
      disp_units_q <= disp_units_d;
      ovf_q        <= ovf_d;
    end
  end

  assign sep_numero = numero_q;
  assign sep_update = update_q;
  assign busy       = (state_q != S_IDLE);
  assign overflow   = ovf_q;

  num_display_ctrl_scan_mux #(
    .NUM_VALUES (NUM_VALUES),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk        (clk),
    .reset_n    (reset_n),
    .blank_lz   (blank_lz),
    .disp_tens  (disp_tens_q),
    .disp_units (disp_units_q),
    .digit_bcd  (digit_bcd),
    .digit_sel  (digit_sel)
  );

endmodule
